// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO; frames go out LSB first with per-frame
// parity/stop format latched at pop time, and queued frames follow each other without gaps.
module uart_tx_fifo #(
    parameter int unsigned OVERSAMPLING = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                                 clk_in,
    input  logic                                 nrst_in,
    input  logic                                 wr_en_in,
    input  logic [DATA_BITS-1:0]                 wr_data_in,
    input  logic [1:0]                           parity_mode_in,
    input  logic                                 stop_bits_in,
    output logic                                 fifo_full_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level_out,
    output logic                                 overflow_out,
    output logic                                 tx_serial_out,
    output logic                                 tx_busy_out,
    output logic                                 tx_done_out
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLING);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLING - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(OVERSAMPLING - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_en;
    logic                   par_bit;
    logic                   stop2;
    logic                   stop_phase;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   bit_end_c;
    logic                   stop_last_c;
    logic                   push_c;
    logic                   pop_c;
    logic [DATA_BITS-1:0]   rd_word_c;
    logic                   par_en_c;
    logic                   par_bit_c;
    logic [LVL_W-1:0]       level_next_c;

    // Handshake between FIFO and serialiser; pops only on frame boundaries
    always_comb begin
        bit_end_c   = (cnt == CNT_LAST);
        stop_last_c = !stop2 || stop_phase;
        push_c      = wr_en_in && !fifo_full_out;
        pop_c       = (fifo_level_out != '0) &&
                      ((state == S_IDLE) ||
                       ((state == S_STOP) && bit_end_c && stop_last_c));
        rd_word_c   = mem[rd_ptr];
        par_en_c    = (parity_mode_in == 2'b01) || (parity_mode_in == 2'b10);
        par_bit_c   = (parity_mode_in == 2'b10) ? ~^rd_word_c : ^rd_word_c;
        level_next_c = fifo_level_out;
        case ({push_c, pop_c})
            2'b10:   level_next_c = fifo_level_out + LVL_W'(1);
            2'b01:   level_next_c = fifo_level_out - LVL_W'(1);
            default: level_next_c = fifo_level_out;
        endcase
    end

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk_in) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data_in;
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level_out <= '0;
            fifo_full_out  <= 1'b0;
            overflow_out   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop_c) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            end
            fifo_level_out <= level_next_c;
            fifo_full_out  <= (level_next_c == LVL_FULL);
            overflow_out   <= wr_en_in && fifo_full_out;
        end
    end

    // Serialiser; tx_serial_out is loaded with the value of the bit being entered
    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state         <= S_IDLE;
            cnt           <= '0;
            idx           <= '0;
            shreg         <= '0;
            par_en        <= 1'b0;
            par_bit       <= 1'b0;
            stop2         <= 1'b0;
            stop_phase    <= 1'b0;
            tx_serial_out <= 1'b1;
            tx_busy_out   <= 1'b0;
            tx_done_out   <= 1'b0;
        end else begin
            tx_done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_serial_out <= 1'b1;
                    tx_busy_out   <= 1'b0;
                    cnt           <= '0;
                end
                S_START: begin
                    if (bit_end_c) begin
                        cnt           <= '0;
                        idx           <= '0;
                        state         <= S_DATA;
                        tx_serial_out <= shreg[0];
                    end else begin
                        cnt <= CNT_W'(cnt + CNT_W'(1));
                    end
                end
                S_DATA: begin
                    if (bit_end_c) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            if (par_en) begin
                                state         <= S_PARITY;
                                tx_serial_out <= par_bit;
                            end else begin
                                state         <= S_STOP;
                                stop_phase    <= 1'b0;
                                tx_serial_out <= 1'b1;
                            end
                        end else begin
                            idx           <= IDX_W'(idx + IDX_W'(1));
                            shreg         <= shreg >> 1;
                            tx_serial_out <= shreg[1];
                        end
                    end else begin
                        cnt <= CNT_W'(cnt + CNT_W'(1));
                    end
                end
                S_PARITY: begin
                    if (bit_end_c) begin
                        cnt           <= '0;
                        state         <= S_STOP;
                        stop_phase    <= 1'b0;
                        tx_serial_out <= 1'b1;
                    end else begin
                        cnt <= CNT_W'(cnt + CNT_W'(1));
                    end
                end
                S_STOP: begin
                    tx_done_out <= (cnt == CNT_DONE) && stop_last_c;
                    if (bit_end_c) begin
                        cnt <= '0;
                        if (!stop_last_c) begin
                            stop_phase <= 1'b1;
                        end else if (!pop_c) begin
                            state         <= S_IDLE;
                            tx_busy_out   <= 1'b0;
                            tx_serial_out <= 1'b1;
                        end
                    end else begin
                        cnt <= CNT_W'(cnt + CNT_W'(1));
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    cnt           <= '0;
                    tx_serial_out <= 1'b1;
                    tx_busy_out   <= 1'b0;
                end
            endcase
            // Frame latch shared by IDLE and the final stop cycle; overrides the case above
            if (pop_c) begin
                state         <= S_START;
                cnt           <= '0;
                shreg         <= rd_word_c;
                par_en        <= par_en_c;
                par_bit       <= par_bit_c;
                stop2         <= stop_bits_in;
                tx_busy_out   <= 1'b1;
                tx_serial_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed steps with random words/config, frames checked against
// a bit-position model of the serial frame recorded from a per-cycle log.
module tb_uart_tx_fifo;

    localparam int OS   = 4;
    localparam int DB   = 8;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [1:0] pmode = '0;
    logic       stop_bits = 1'b0;
    logic       full, overflow, tx, busy, done;
    logic [2:0] level;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.OVERSAMPLING(OS), .DATA_BITS(DB), .FIFO_DEPTH(4)) dut (
        .clk_in(clk), .nrst_in(nrst), .wr_en_in(wr_en), .wr_data_in(wr_data),
        .parity_mode_in(pmode), .stop_bits_in(stop_bits), .fifo_full_out(full),
        .fifo_level_out(level), .overflow_out(overflow), .tx_serial_out(tx),
        .tx_busy_out(busy), .tx_done_out(done)
    );

    always #5 clk = ~clk;

    // Per-cycle record of the line, taken mid-cycle
    int   cyc = 0;
    logic line_log [MAXC];
    logic done_log [MAXC];
    logic busy_log [MAXC];

    always @(negedge clk) begin
        if (cyc < MAXC - 2) cyc = cyc + 1;
        line_log[cyc] = tx;
        done_log[cyc] = done;
        busy_log[cyc] = busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic bit par_on(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    function automatic int frame_len(input logic [1:0] m, input logic s2);
        return (1 + DB + (par_on(m) ? 1 : 0) + (s2 ? 2 : 1)) * OS;
    endfunction

    // Expected line level k cycles after the start edge
    function automatic logic exp_line(input logic [7:0] w, input logic [1:0] m, input int k);
        int b;
        b = k / OS;
        if (b == 0) return 1'b0;
        if (b <= DB) return w[b-1];
        if (par_on(m) && b == DB + 1) return (m == 2'b01) ? ^w : ~^w;
        return 1'b1;
    endfunction

    task automatic check_frame(input int s, input logic [7:0] w, input logic [1:0] m,
                               input logic s2, input bit last, input string tag);
        int len;
        logic [63:0] el, al, ed, ad, eb, ab;
        len = frame_len(m, s2);
        el = '0; al = '0; ed = '0; ad = '0; eb = '0; ab = '0;
        for (int k = 0; k < len; k++) begin
            el[k] = exp_line(w, m, k);
            al[k] = line_log[s + k];
            ed[k] = (k == len - 1);
            ad[k] = done_log[s + k];
            eb[k] = 1'b1;
            ab[k] = busy_log[s + k];
        end
        chk({tag, "_line"}, al, el);
        chk({tag, "_done"}, ad, ed);
        chk({tag, "_busy"}, ab, eb);
        if (last) begin
            chk({tag, "_end_line"}, 64'(line_log[s + len]), 64'(1));
            chk({tag, "_end_busy"}, 64'(busy_log[s + len]), 64'(0));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || level != 0) && n < 600) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 64'(busy || level != 0), 64'(0));
        tick();
    endtask

    task automatic send_one(input logic [7:0] w, input logic [1:0] m, input logic s2,
                            input bit scramble, input string tag);
        int s;
        pmode = m;
        stop_bits = s2;
        do_write(w);
        chk({tag, "_lvl_after_wr"}, 64'(level), 64'(1));
        chk({tag, "_line_before"}, 64'(tx), 64'(1));
        tick();
        chk({tag, "_start_low"}, 64'(tx), 64'(0));
        s = cyc + 1;
        if (scramble) begin
            for (int i = 0; i < frame_len(m, s2) - 2; i++) begin
                pmode = 2'($urandom);
                stop_bits = 1'($urandom);
                tick();
            end
            pmode = m;
            stop_bits = s2;
        end
        wait_idle(tag);
        check_frame(s, w, m, s2, 1'b1, tag);
    endtask

    initial begin
        logic [7:0] w [6];
        logic [1:0] m;
        logic       s2;
        int         s;
        int         len;
        int         exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
        int         exp_full[6] = '{0, 0, 0, 0, 1, 1};
        int         exp_ovf [6] = '{0, 0, 0, 0, 0, 1};

        repeat (3) @(posedge clk);
        #2 nrst = 1'b1;
        chk("rst_line", 64'(tx), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        tick();

        send_one(8'hA5, 2'b00, 1'b0, 1'b0, "t1");
        send_one(8'h07, 2'b01, 1'b0, 1'b0, "t2_even");
        send_one(8'h07, 2'b10, 1'b0, 1'b0, "t2_odd");
        send_one(8'h00, 2'b00, 1'b1, 1'b1, "t3");
        for (int i = 0; i < 4; i++) begin
            send_one(8'($urandom), 2'($urandom), 1'($urandom), 1'b1, "rnd");
        end

        // Burst of six writes into an idle transmitter
        m  = 2'($urandom);
        s2 = 1'($urandom);
        pmode = m;
        stop_bits = s2;
        s = 0;
        for (int i = 0; i < 6; i++) begin
            w[i] = 8'($urandom);
            wr_en = 1'b1;
            wr_data = w[i];
            tick();
            if (i == 1) s = cyc + 1;
            chk("t4_level", 64'(level), 64'(exp_lvl[i]));
            chk("t4_full", 64'(full), 64'(exp_full[i]));
            chk("t4_ovf", 64'(overflow), 64'(exp_ovf[i]));
        end
        wr_en = 1'b0;
        tick();
        chk("t4_ovf_pulse_end", 64'(overflow), 64'(0));
        wait_idle("t4");
        len = frame_len(m, s2);
        for (int i = 0; i < 5; i++) begin
            check_frame(s + i * len, w[i], m, s2, i == 4, "t4_frame");
        end

        // Reset in the middle of a data bit with one word still queued
        pmode = 2'b00;
        stop_bits = 1'b0;
        do_write(8'($urandom));
        do_write(8'($urandom));
        repeat (12) tick();
        chk("t5_busy_pre", 64'(busy), 64'(1));
        nrst = 1'b0;
        #1;
        chk("t5_rst_line", 64'(tx), 64'(1));
        chk("t5_rst_busy", 64'(busy), 64'(0));
        chk("t5_rst_level", 64'(level), 64'(0));
        #4 nrst = 1'b1;
        tick();
        chk("t5_idle_after", 64'(tx), 64'(1));
        send_one(8'($urandom), 2'($urandom), 1'($urandom), 1'b0, "t5_new");

        // Push on the same edge as the back-to-back pop
        m  = 2'($urandom);
        s2 = 1'($urandom);
        pmode = m;
        stop_bits = s2;
        w[0] = 8'($urandom);
        w[1] = 8'($urandom);
        w[2] = 8'($urandom);
        len = frame_len(m, s2);
        do_write(w[0]);
        do_write(w[1]);
        s = cyc + 1;
        chk("t6_level_q", 64'(level), 64'(1));
        repeat (len - 1) tick();
        chk("t6_done_last", 64'(done), 64'(1));
        wr_en = 1'b1;
        wr_data = w[2];
        tick();
        wr_en = 1'b0;
        chk("t6_level_same", 64'(level), 64'(1));
        chk("t6_next_start", 64'(tx), 64'(0));
        chk("t6_busy_held", 64'(busy), 64'(1));
        wait_idle("t6");
        check_frame(s, w[0], m, s2, 1'b0, "t6_f0");
        check_frame(s + len, w[1], m, s2, 1'b0, "t6_f1");
        check_frame(s + 2 * len, w[2], m, s2, 1'b1, "t6_f2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
